vga_draw_arbiter: RTL and testbench
===================================

// Module: vga_draw_arbiter
// PURPOSE
//  Shares the single VGA adapter plot port between drawing objects (dot, pipe columns, score).
//  Each requester asks for a filled rectangle at (x,y) of size w x h in one colour.
//  Round-robin arbitration picks one request; a scanner emits one pixel per clk50 cycle to the adapter.
//  Sits between the object datapaths (erase/draw colour generators) and the vga_adapter instance.
// PARAMETERS
//  NUM_REQ   3    number of requesters (1..8)
//  SZ_BITS   4    width of rectangle size fields; max side = 2**SZ_BITS-1 pixels
//  SCR_W     160  screen width; pixels with x >= SCR_W are clipped
//  SCR_H     120  screen height; pixels with y >= SCR_H are clipped
// PORTS
//  clk50       in   1              system clock, 50 MHz
//  reset       in   1              synchronous, active-high reset
//  req         in   NUM_REQ        per-requester draw request, level
//  req_x       in   8*NUM_REQ      top-left x, requester i at [8i+7:8i]
//  req_y       in   7*NUM_REQ      top-left y, requester i at [7i+6:7i]
//  req_w       in   SZ_BITS*NUM_REQ  rectangle width in pixels
//  req_h       in   SZ_BITS*NUM_REQ  rectangle height in pixels
//  req_colour  in   3*NUM_REQ      fill colour (3'b000 = erase)
//  grant       out  NUM_REQ        one-hot; owner of the plot port
//  done        out  NUM_REQ        one-cycle pulse when the owner's rectangle is finished
//  vga_x       out  8              pixel x to adapter
//  vga_y       out  7              pixel y to adapter
//  vga_colour  out  3              pixel colour to adapter
//  vga_plot    out  1              write-enable to adapter
//  busy        out  1              high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE, grant=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, busy=0.
//    RR pointer resets to requester 0 (highest priority).
//  FSM: IDLE -> LOAD -> SCAN -> DONE -> IDLE.
//   IDLE: if any req, select the first requester at or after the RR pointer, then go to LOAD.
//         If no req, stay in IDLE.
//   LOAD: register the winner's x,y,w,h,colour; assert grant[i]; set the RR pointer to i+1 mod NUM_REQ.
//         If w==0 or h==0, go directly to DONE with no pixels; otherwise go to SCAN with dx=dy=0.
//   SCAN: each cycle, output x+dx and y+dy (9-bit sums) with the latched colour.
//         dx increments; when dx==w-1, set dx=0 and increment dy.
//         Leave for DONE after the pixel dx==w-1, dy==h-1. Exactly w*h SCAN cycles.
//   DONE: done[i]=1 for this cycle only; grant drops on entering IDLE.
//  grant stays high from LOAD through DONE inclusive.
//  Requester contract: req, x, y, w, h and colour are stable from req rising until grant rises.
//  After grant, the inputs may change freely; the latched copy is used.
//  A requester must drop req by the cycle after done, or it is re-arbitrated as a new request.
//  vga_plot is registered: high one cycle after each SCAN pixel is computed.
//    It goes low for clipped pixels (x+dx >= SCR_W or y+dy >= SCR_H); those cycles are still consumed.
//  Coordinate sums never wrap: 9-bit / 8-bit arithmetic, clipped rather than wrapped.
//  Simultaneous requests: RR order. A requester that just finished has lowest priority next arbitration.
//  req dropped mid-SCAN: ignored; the rectangle completes.
//  Reset mid-SCAN: abort immediately; no done pulse; plot low on the next cycle.
//  Latency: req rising in IDLE -> grant 1 cycle later -> first vga_plot 2 cycles after grant -> done.
//    Total = 3 + w*h cycles, req to done.
// STRUCTURE
//  Shared package/include: state encodings (IDLE, LOAD, SCAN, DONE); SCR_W and SCR_H defaults.
//  Sub-module rect_scanner: latched origin/size -> dx/dy counters, clip, registered vga_* and last flag.
//  Top holds the FSM, the RR pointer and the priority select.
// TESTING
//  1 Single req[0], (10,20) w=2 h=2 col=101:
//    plots (10,20) (11,20) (10,21) (11,21) in order; done[0] 7 cycles after req.
//  2 req[0] and req[2] rise together, pointer=0:
//    grant[0] first, then grant[2]; with req[0] still held, next grant goes to req[1] or req[2] before req[0].
//  3 (158,119) w=4 h=2:
//    only (158,119) and (159,119) plotted; 8 SCAN cycles elapse; done still pulses.
//  4 w=0 h=5: no vga_plot; done pulses 2 cycles after grant.
//  5 Reset asserted mid-SCAN of a 15x15 rect:
//    outputs at reset values next cycle; no done; a new req is served normally.
//  6 req[1] inputs changed right after grant:
//    all pixels use the latched values; single done[1] pulse.

Source files
------------

// File: rtl/vga_draw_arbiter_pkg.sv
// Shared definitions for the VGA draw arbiter: FSM states and default screen size.
package vga_draw_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_DONE
  } state_e;

  localparam int SCR_W_DEF = 160;
  localparam int SCR_H_DEF = 120;

endpackage

// File: rtl/vga_draw_arbiter_rect_scanner.sv
// Latches a rectangle and walks it row by row, one pixel per clock, with
// off-screen pixels suppressed on the registered plot strobe.
module rect_scanner
  import vga_draw_arbiter_pkg::*;
#(
  parameter int SZ_BITS = 4,
  parameter int SCR_W   = SCR_W_DEF,
  parameter int SCR_H   = SCR_H_DEF
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               load_i,
  input  logic               run_i,
  input  logic [7:0]         x_i,
  input  logic [6:0]         y_i,
  input  logic [SZ_BITS-1:0] w_i,
  input  logic [SZ_BITS-1:0] h_i,
  input  logic [2:0]         colour_i,
  output logic               empty_o,
  output logic               last_o,
  output logic [7:0]         vga_x_o,
  output logic [6:0]         vga_y_o,
  output logic [2:0]         vga_colour_o,
  output logic               vga_plot_o
);

  logic [7:0]         org_x_q;
  logic [6:0]         org_y_q;
  logic [SZ_BITS-1:0] w_q, h_q, dx_q, dy_q;
  logic [2:0]         colour_q;
  logic [7:0]         vga_x_q;
  logic [6:0]         vga_y_q;
  logic [2:0]         vga_colour_q;
  logic               vga_plot_q;

  // One spare bit on each sum so edge-of-screen origins clip instead of wrapping.
  logic [8:0] sum_x_d;
  logic [7:0] sum_y_d;
  logic       dx_end_d, dy_end_d;

  assign sum_x_d  = {1'b0, org_x_q} + 9'(dx_q);
  assign sum_y_d  = {1'b0, org_y_q} + 8'(dy_q);
  assign dx_end_d = (dx_q == w_q - SZ_BITS'(1));
  assign dy_end_d = (dy_q == h_q - SZ_BITS'(1));

  assign empty_o      = (w_q == '0) || (h_q == '0);
  assign last_o       = dx_end_d && dy_end_d;
  assign vga_x_o      = vga_x_q;
  assign vga_y_o      = vga_y_q;
  assign vga_colour_o = vga_colour_q;
  assign vga_plot_o   = vga_plot_q;

  always_ff @(posedge clk50) begin
    if (reset) begin
      org_x_q      <= '0;
      org_y_q      <= '0;
      w_q          <= '0;
      h_q          <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      colour_q     <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      if (load_i) begin
        org_x_q  <= x_i;
        org_y_q  <= y_i;
        w_q      <= w_i;
        h_q      <= h_i;
        colour_q <= colour_i;
        dx_q     <= '0;
        dy_q     <= '0;
      end
      if (run_i) begin
        vga_x_q      <= sum_x_d[7:0];
        vga_y_q      <= sum_y_d[6:0];
        vga_colour_q <= colour_q;
        vga_plot_q   <= (sum_x_d < 9'(SCR_W)) && (sum_y_d < 8'(SCR_H));
        if (dx_end_d) begin
          dx_q <= '0;
          dy_q <= dy_q + SZ_BITS'(1);
        end else begin
          dx_q <= dx_q + SZ_BITS'(1);
        end
      end else begin
        vga_plot_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the VGA plot port: picks a requester, scans its
// rectangle through rect_scanner and pulses done when it is finished.
module vga_draw_arbiter
  import vga_draw_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int SZ_BITS = 4,
  parameter int SCR_W   = SCR_W_DEF,
  parameter int SCR_H   = SCR_H_DEF
) (
  input  logic                       clk50,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_x,
  input  logic [7*NUM_REQ-1:0]       req_y,
  input  logic [SZ_BITS*NUM_REQ-1:0] req_w,
  input  logic [SZ_BITS*NUM_REQ-1:0] req_h,
  input  logic [3*NUM_REQ-1:0]       req_colour,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         done,
  output logic [7:0]                 vga_x,
  output logic [6:0]                 vga_y,
  output logic [2:0]                 vga_colour,
  output logic                       vga_plot,
  output logic                       busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q;
  logic [IW-1:0]        ptr_q, sel_q;
  logic [NUM_REQ-1:0]   grant_q, done_q;

  logic [7:0]           rx [NUM_REQ];
  logic [6:0]           ry [NUM_REQ];
  logic [SZ_BITS-1:0]   rw [NUM_REQ];
  logic [SZ_BITS-1:0]   rh [NUM_REQ];
  logic [2:0]           rc [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign rx[gi] = req_x[8*gi +: 8];
    assign ry[gi] = req_y[7*gi +: 7];
    assign rw[gi] = req_w[SZ_BITS*gi +: SZ_BITS];
    assign rh[gi] = req_h[SZ_BITS*gi +: SZ_BITS];
    assign rc[gi] = req_colour[3*gi +: 3];
  end

  // Rotate so the pointer sits at bit 0, take the lowest set bit, rotate back.
  logic [NUM_REQ-1:0] req_rot_d;
  logic [IW:0]        off_d, win_sum_d;
  logic [IW-1:0]      win_d;
  logic               arb_go_d;

  assign req_rot_d = NUM_REQ'({req, req} >> ptr_q);

  always_comb begin
    off_d = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot_d[k]) off_d = (IW+1)'(k);
    end
    win_sum_d = {1'b0, ptr_q} + off_d;
    if (win_sum_d >= (IW+1)'(NUM_REQ)) win_sum_d = win_sum_d - (IW+1)'(NUM_REQ);
    win_d = win_sum_d[IW-1:0];
  end

  // While done is still showing, the finished requester may not have dropped req yet.
  assign arb_go_d = (state_q == ST_IDLE) && (|req) && !(|done_q);

  logic scan_empty, scan_last;

  rect_scanner #(
    .SZ_BITS (SZ_BITS),
    .SCR_W   (SCR_W),
    .SCR_H   (SCR_H)
  ) u_scanner (
    .clk50        (clk50),
    .reset        (reset),
    .load_i       (arb_go_d),
    .run_i        (state_q == ST_SCAN),
    .x_i          (rx[win_d]),
    .y_i          (ry[win_d]),
    .w_i          (rw[win_d]),
    .h_i          (rh[win_d]),
    .colour_i     (rc[win_d]),
    .empty_o      (scan_empty),
    .last_o       (scan_last),
    .vga_x_o      (vga_x),
    .vga_y_o      (vga_y),
    .vga_colour_o (vga_colour),
    .vga_plot_o   (vga_plot)
  );

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (arb_go_d) begin
            sel_q   <= win_d;
            grant_q <= NUM_REQ'(1) << win_d;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          ptr_q   <= (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + IW'(1);
          state_q <= scan_empty ? ST_DONE : ST_SCAN;
        end
        ST_SCAN: begin
          if (scan_last) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= grant_q;
          grant_q <= '0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench: stimulus predicts grant order, pixels and done timing;
// a negedge monitor pops and compares whatever the arbiter presents.
module tb_vga_draw_arbiter;

  localparam int N  = 3;
  localparam int SZ = 4;

  logic            clk50 = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [8*N-1:0]  req_x;
  logic [7*N-1:0]  req_y;
  logic [SZ*N-1:0] req_w, req_h;
  logic [3*N-1:0]  req_colour;
  logic [N-1:0]    grant, done;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot, busy;

  vga_draw_arbiter #(.NUM_REQ(N), .SZ_BITS(SZ), .SCR_W(160), .SCR_H(120)) dut (
    .clk50(clk50), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .grant(grant),
    .done(done), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy)
  );

  always #10 clk50 = ~clk50;

  int cyc = 0;
  always @(posedge clk50) cyc <= cyc + 1;

  typedef struct { int x; int y; int c; } pix_t;
  typedef struct { int idx; int t; } ev_t;

  pix_t pix_exp[$];
  ev_t  grant_exp[$];
  ev_t  done_exp[$];

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  logic [N-1:0] done_seen = '0;
  logic [N-1:0] prev_grant = '0;

  // Monitor
  always @(negedge clk50) begin
    pix_t p;
    ev_t  e;
    if (!reset) begin
      if (vga_plot) begin
        checks++;
        if (pix_exp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_plot got (%0d,%0d,%0d) required no plot", vga_x, vga_y, vga_colour);
        end else begin
          p = pix_exp.pop_front();
          if (vga_x != 8'(p.x) || vga_y != 7'(p.y) || vga_colour != 3'(p.c)) begin
            errors++;
            $display("FAIL pixel got (%0d,%0d,%0d) required (%0d,%0d,%0d)",
                     vga_x, vga_y, vga_colour, p.x, p.y, p.c);
          end
        end
      end
      if (grant != '0 && prev_grant == '0) begin
        checks++;
        if (grant_exp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant got %b cyc %0d required none", grant, cyc);
        end else begin
          e = grant_exp.pop_front();
          if (grant != N'(1 << e.idx) || cyc != e.t) begin
            errors++;
            $display("FAIL grant got %b at cyc %0d required %b at cyc %0d", grant, cyc, N'(1 << e.idx), e.t);
          end
        end
      end
      if (done != '0) begin
        checks++;
        if (done_exp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done got %b cyc %0d required none", done, cyc);
        end else begin
          e = done_exp.pop_front();
          if (done != N'(1 << e.idx) || cyc != e.t) begin
            errors++;
            $display("FAIL done got %b at cyc %0d required %b at cyc %0d", done, cyc, N'(1 << e.idx), e.t);
          end
        end
        done_seen = done_seen | done;
      end
    end
    prev_grant = grant;
  end

  task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
    req_x[i*8 +: 8]       = 8'(x);
    req_y[i*7 +: 7]       = 7'(y);
    req_w[i*SZ +: SZ]     = SZ'(w);
    req_h[i*SZ +: SZ]     = SZ'(h);
    req_colour[i*3 +: 3]  = 3'(c);
  endtask

  task automatic push_pixels(input int i);
    int x, y, w, h, c;
    x = int'(req_x[i*8 +: 8]);
    y = int'(req_y[i*7 +: 7]);
    w = int'(req_w[i*SZ +: SZ]);
    h = int'(req_h[i*SZ +: SZ]);
    c = int'(req_colour[i*3 +: 3]);
    for (int r = 0; r < h; r++)
      for (int q = 0; q < w; q++)
        if (x + q < 160 && y + r < 120) pix_exp.push_back('{x + q, y + r, c});
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({grant, done, vga_x, vga_y, vga_colour, vga_plot, busy} != '0) begin
      errors++;
      $display("FAIL %s got grant=%b done=%b xy=(%0d,%0d) col=%0d plot=%b busy=%b required all zero",
               name, grant, done, vga_x, vga_y, vga_colour, vga_plot, busy);
    end
  endtask

  // Serve every requester in mask: requests raised together, served in RR order
  // starting at the model pointer; each drops req once its done has been seen.
  task automatic serve(input logic [N-1:0] mask);
    int order[$];
    int t, gt, i, wh, budget;
    logic [N-1:0] pend, scr;
    for (int k = 0; k < N; k++) begin
      i = (model_ptr + k) % N;
      if (mask[i]) order.push_back(i);
    end
    gt = cyc + 1;
    t  = 0;
    foreach (order[j]) begin
      i  = order[j];
      wh = int'(req_w[i*SZ +: SZ]) * int'(req_h[i*SZ +: SZ]);
      grant_exp.push_back('{i, gt});
      push_pixels(i);
      t = (j == 0) ? cyc + 3 + wh : t + 4 + wh;
      done_exp.push_back('{i, t});
      gt = t + 2;
      model_ptr = (i + 1) % N;
    end
    $display("serve mask=%b order=%p last_done_cyc=%0d", mask, order, t);
    done_seen = '0;
    scr  = '0;
    pend = mask;
    req  = req | mask;
    budget = 0;
    while (pend != '0 && budget < 2000) begin
      @(posedge clk50); #1;
      budget++;
      for (int k = 0; k < N; k++) begin
        if (grant[k] && !scr[k]) begin
          scr[k] = 1'b1;
          set_rect(k, $urandom_range(0, 255), $urandom_range(0, 127),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
        end
        if (done_seen[k]) begin
          req[k] = 1'b0;
          done_seen[k] = 1'b0;
          pend[k] = 1'b0;
        end
      end
    end
    if (pend != '0) begin
      checks++;
      errors++;
      $display("FAIL serve_timeout pending=%b required %b", pend, N'(0));
      req = '0;
    end
    repeat (3) @(posedge clk50);
    #1;
  endtask

  initial begin
    logic [N-1:0] m;
    reset = 1'b1;
    req = '0; req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (3) @(posedge clk50);
    #1;
    check_reset("reset_state");
    reset = 1'b0;
    @(posedge clk50); #1;

    // Simultaneous req[0] and req[2] with pointer at 0.
    set_rect(0, 30, 40, 3, 2, 3'b011);
    set_rect(2, 50, 60, 2, 3, 3'b110);
    serve(3'b101);
    // Single 2x2 at (10,20).
    set_rect(0, 10, 20, 2, 2, 3'b101);
    serve(3'b001);
    // Bottom-right clipping.
    set_rect(1, 158, 119, 4, 2, 3'b111);
    serve(3'b010);
    // Zero width.
    set_rect(2, 40, 40, 0, 5, 3'b001);
    serve(3'b100);

    // Reset in the middle of a 15x15 scan.
    set_rect(0, 5, 5, 15, 15, 3'b010);
    grant_exp.push_back('{0, cyc + 1});
    push_pixels(0);
    req[0] = 1'b1;
    repeat (20) @(posedge clk50);
    #1;
    reset = 1'b1;
    req = '0;
    @(posedge clk50); #1;
    check_reset("reset_mid_scan");
    $display("reset mid-scan applied at cyc %0d", cyc);
    pix_exp.delete();
    grant_exp.delete();
    done_exp.delete();
    model_ptr = 0;
    reset = 1'b0;
    repeat (2) @(posedge clk50);
    #1;

    for (int n = 0; n < 30; n++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if (m[i]) begin
          set_rect(i,
                   ($urandom_range(0, 3) == 0) ? $urandom_range(140, 255) : $urandom_range(0, 159),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(105, 127) : $urandom_range(0, 119),
                   $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
        end
      end
      serve(m);
    end

    checks++;
    if (pix_exp.size() != 0 || grant_exp.size() != 0 || done_exp.size() != 0) begin
      errors++;
      $display("FAIL leftover got pix=%0d grant=%0d done=%0d required 0 0 0",
               pix_exp.size(), grant_exp.size(), done_exp.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
